// File: rtl/pll_phase_ctrl.sv
// pll_phase_ctrl: waits for a stable PLL lock, then releases the downstream
// reset. It also sequences dynamic-phase steps on the PLL phasesel,
// phasedir and phasestep pins in response to step requests.
//
// Request handshake: a request transfers on a rising clock edge where both
// req_valid and req_ready are 1. req_ready is 1 only in IDLE while the
// synchronised lock is high. It does not depend on req_valid. A requester
// that raises req_valid keeps it and its payload stable until the transfer
// edge.
module pll_phase_ctrl #(
  parameter int LOCK_STABLE = 1024,
  parameter int STEP_SETUP  = 4,
  parameter int STEP_PULSE  = 4,
  parameter int STEP_GAP    = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pll_locked,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_sel,
  input  logic        req_dir,
  input  logic [7:0]  req_count,
  output logic [1:0]  phasesel,
  output logic        phasedir,
  output logic        phasestep,
  output logic        phaseloadreg,
  output logic        sys_reset,
  output logic        busy,
  output logic        lock_lost,
  output logic [15:0] steps_done,
  output logic [2:0]  state_dbg
);

  // A single counter serves the lock-stability wait and every step phase,
  // so it is sized for the longest of them.
  localparam int MAX_AB = (STEP_SETUP > STEP_PULSE) ? STEP_SETUP : STEP_PULSE;
  localparam int MAX_CD = (STEP_GAP > LOCK_STABLE) ? STEP_GAP : LOCK_STABLE;
  localparam int MAX_V  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAX_V + 1);

  localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(STEP_SETUP - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(STEP_PULSE - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(STEP_GAP - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    IDLE      = 3'd2,
    SETUP     = 3'd3,
    PULSE     = 3'd4,
    GAP       = 3'd5
  } state_t;

  state_t        state, state_n;
  logic          lock_meta, lock_sync;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    remaining, remaining_n;
  logic [1:0]    sel_n;
  logic          dir_n;
  logic          lost_n;
  logic [15:0]   steps_n;
  logic          handshake;

  // pll_locked comes from the PLL domain, so it is double-flopped before use.
  always_ff @(posedge clock) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_sync <= lock_meta;
    end
  end

  // Requests are gated on lock so that a request offered during a lock drop
  // is held off, not swallowed by the lock-loss path.
  assign req_ready    = (state == IDLE) && lock_sync;
  assign handshake    = req_valid && req_ready;
  assign phaseloadreg = 1'b1;
  assign state_dbg    = state;

  // Next-state, counter and step bookkeeping.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    remaining_n = remaining;
    sel_n       = phasesel;
    dir_n       = phasedir;
    lost_n      = lock_lost;
    steps_n     = steps_done;

    case (state)
      WAIT_LOCK: begin
        cnt_n = '0;
        if (lock_sync) state_n = STABLE;
      end
      STABLE: begin
        if (!lock_sync) begin
          cnt_n   = '0;
          state_n = WAIT_LOCK;
        end else if (cnt == LOCK_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      IDLE: begin
        cnt_n = '0;
        // A zero-count request is consumed here with no effect.
        if (handshake && (req_count != 8'd0)) begin
          sel_n       = req_sel;
          dir_n       = req_dir;
          remaining_n = req_count;
          state_n     = SETUP;
        end
      end
      SETUP: begin
        if (cnt == SETUP_LAST) begin
          cnt_n   = '0;
          state_n = PULSE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PULSE: begin
        if (cnt == PULSE_LAST) begin
          cnt_n       = '0;
          remaining_n = remaining - 8'd1;
          steps_n     = steps_done + 16'd1;
          state_n     = GAP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n   = '0;
          state_n = (remaining != 8'd0) ? PULSE : IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = WAIT_LOCK;
      end
    endcase

    // Losing lock after the downstream reset has been released aborts
    // everything. A pulse cut short here is not counted as a completed step.
    if ((state inside {IDLE, SETUP, PULSE, GAP}) && !lock_sync) begin
      state_n     = WAIT_LOCK;
      cnt_n       = '0;
      remaining_n = 8'd0;
      lost_n      = 1'b1;
      steps_n     = steps_done;
    end
  end

  // State and registered outputs. The pin outputs are decoded from the next
  // state so that they change on the same edge as the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= WAIT_LOCK;
      cnt        <= '0;
      remaining  <= 8'd0;
      phasesel   <= 2'd0;
      phasedir   <= 1'b0;
      phasestep  <= 1'b1;
      sys_reset  <= 1'b1;
      busy       <= 1'b0;
      lock_lost  <= 1'b0;
      steps_done <= 16'd0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      remaining  <= remaining_n;
      phasesel   <= sel_n;
      phasedir   <= dir_n;
      phasestep  <= (state_n != PULSE);
      sys_reset  <= (state_n inside {WAIT_LOCK, STABLE});
      busy       <= (state_n inside {SETUP, PULSE, GAP});
      lock_lost  <= lost_n;
      steps_done <= steps_n;
    end
  end

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Testbench for pll_phase_ctrl, with LOCK_STABLE = 16 and default step
// timing. Directed stimulus pushes the expected pulse and busy records into
// queues. A monitor measures each low phasestep pulse and each busy window,
// and compares the measurements against those queues.
module tb_pll_phase_ctrl;

  localparam int LOCK_STABLE = 16;

  logic        clock;
  logic        reset;
  logic        pll_locked;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_sel;
  logic        req_dir;
  logic [7:0]  req_count;
  logic [1:0]  phasesel;
  logic        phasedir;
  logic        phasestep;
  logic        phaseloadreg;
  logic        sys_reset;
  logic        busy;
  logic        lock_lost;
  logic [15:0] steps_done;
  logic [2:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // {phasesel, phasedir, low length} of each expected pulse
  logic [10:0] pulse_q[$];
  // length in cycles of each expected busy window
  logic [7:0]  busy_q[$];

  pll_phase_ctrl #(
    .LOCK_STABLE(LOCK_STABLE),
    .STEP_SETUP (4),
    .STEP_PULSE (4),
    .STEP_GAP   (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .pll_locked  (pll_locked),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_sel     (req_sel),
    .req_dir     (req_dir),
    .req_count   (req_count),
    .phasesel    (phasesel),
    .phasedir    (phasedir),
    .phasestep   (phasestep),
    .phaseloadreg(phaseloadreg),
    .sys_reset   (sys_reset),
    .busy        (busy),
    .lock_lost   (lock_lost),
    .steps_done  (steps_done),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},        32'(state_dbg), 32'd0);
    check({tag, "_sys_reset"},    32'(sys_reset), 32'd1);
    check({tag, "_req_ready"},    32'(req_ready), 32'd0);
    check({tag, "_busy"},         32'(busy), 32'd0);
    check({tag, "_phasesel"},     32'(phasesel), 32'd0);
    check({tag, "_phasedir"},     32'(phasedir), 32'd0);
    check({tag, "_phasestep"},    32'(phasestep), 32'd1);
    check({tag, "_phaseloadreg"}, 32'(phaseloadreg), 32'd1);
    check({tag, "_lock_lost"},    32'(lock_lost), 32'd0);
    check({tag, "_steps_done"},   32'(steps_done), 32'd0);
  endtask

  // Offer a request, wait for acceptance and queue the expected outcome.
  // The task returns just after the transfer edge.
  task automatic send_req(input logic [1:0] sel, input logic dir, input logic [7:0] cnt,
                          input int exp_busy, input int n_pulses, input int last_len);
    int n;
    req_sel   = sel;
    req_dir   = dir;
    req_count = cnt;
    req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("req_accept_in_time", 32'(n < 200), 32'd1);
    if (n < 200) begin
      for (int i = 0; i < n_pulses; i++)
        pulse_q.push_back({sel, dir, 8'((i == n_pulses - 1) ? last_len : 4)});
      if (exp_busy > 0) busy_q.push_back(8'(exp_busy));
      tick();
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check(name, 32'(n < 200), 32'd1);
  endtask

  // monitor / scoreboard
  initial begin : monitor
    logic [7:0]  plen, blen;
    logic [1:0]  psel, prev_sel;
    logic        pdir, prev_dir;
    logic        in_pulse, in_busy, moved;
    logic [10:0] pe;
    logic [7:0]  be;
    in_pulse = 1'b0;
    in_busy  = 1'b0;
    moved    = 1'b0;
    plen     = 8'd0;
    blen     = 8'd0;
    psel     = 2'd0;
    pdir     = 1'b0;
    prev_sel = 2'd0;
    prev_dir = 1'b0;
    forever begin
      @(negedge clock);
      if (phasestep === 1'b0) begin
        if (!in_pulse) begin
          in_pulse = 1'b1;
          plen     = 8'd0;
          psel     = phasesel;
          pdir     = phasedir;
        end
        plen++;
      end else if (in_pulse) begin
        in_pulse = 1'b0;
        if (pulse_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: got sel=%0d dir=%0d len=%0d expected no pulse", psel, pdir, plen);
        end else begin
          pe = pulse_q.pop_front();
          check("pulse_sel_dir_len", 32'({psel, pdir, plen}), 32'(pe));
        end
      end

      if (busy === 1'b1) begin
        if (!in_busy) begin
          in_busy = 1'b1;
          blen    = 8'd0;
          moved   = 1'b0;
        end else if (phasesel !== prev_sel || phasedir !== prev_dir) begin
          moved = 1'b1;
        end
        blen++;
        prev_sel = phasesel;
        prev_dir = phasedir;
      end else if (in_busy) begin
        in_busy = 1'b0;
        check("sel_dir_stable_while_busy", 32'(moved), 32'd0);
        if (busy_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_busy: got len=%0d expected no busy window", blen);
        end else begin
          be = busy_q.pop_front();
          check("busy_len", 32'(blen), 32'(be));
        end
      end
    end
  end

  // directed stimulus
  initial begin : stimulus
    int n;
    reset      = 1'b1;
    pll_locked = 1'b0;
    req_valid  = 1'b0;
    req_sel    = 2'd0;
    req_dir    = 1'b0;
    req_count  = 8'd0;
    repeat (3) tick();
    check_reset_values("por");
    reset = 1'b0;

    // No lock yet: the downstream reset stays asserted.
    repeat (10) tick();
    check("nolock_sys_reset", 32'(sys_reset), 32'd1);
    check("nolock_req_ready", 32'(req_ready), 32'd0);

    // Glitchy lock: high 10 cycles, low 1, then high for good.
    pll_locked = 1'b1;
    repeat (10) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    n = 0;
    while (sys_reset === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("relock_cycles_to_release", 32'(n), 32'd18);
    check("release_req_ready", 32'(req_ready), 32'd1);
    check("release_state_idle", 32'(state_dbg), 32'd2);
    check("release_busy", 32'(busy), 32'd0);

    // Single request: sel=2, dir=1, count=3, busy 4+3*12.
    send_req(2'd2, 1'b1, 8'd3, 40, 3, 4);
    check("setup_phasesel", 32'(phasesel), 32'd2);
    check("setup_phasedir", 32'(phasedir), 32'd1);
    check("setup_busy", 32'(busy), 32'd1);
    check("setup_phasestep", 32'(phasestep), 32'd1);
    check("setup_req_ready", 32'(req_ready), 32'd0);
    wait_ready("single_req_done");
    check("single_steps_done", 32'(steps_done), 32'd3);

    // A zero-count request is consumed without any step.
    send_req(2'd1, 1'b0, 8'd0, 0, 0, 4);
    check("zero_req_ready", 32'(req_ready), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    repeat (20) tick();
    check("zero_steps_done", 32'(steps_done), 32'd3);

    // Lock drop during the 2nd pulse of a count=5 request.
    send_req(2'd1, 1'b0, 8'd5, 19, 2, 3);
    repeat (16) tick();
    check("drop_in_pulse2", 32'(phasestep), 32'd0);
    pll_locked = 1'b0;
    repeat (3) tick();
    check("drop_phasestep_high", 32'(phasestep), 32'd1);
    check("drop_lock_lost", 32'(lock_lost), 32'd1);
    check("drop_steps_done", 32'(steps_done), 32'd4);
    check("drop_sys_reset", 32'(sys_reset), 32'd1);
    check("drop_busy", 32'(busy), 32'd0);
    pll_locked = 1'b1;
    wait_ready("drop_relock");
    repeat (30) tick();
    check("drop_after_steps_done", 32'(steps_done), 32'd4);
    check("drop_after_lock_lost", 32'(lock_lost), 32'd1);
    check("drop_after_state_idle", 32'(state_dbg), 32'd2);

    // Reset asserted in the first gap of a count=3 request.
    send_req(2'd3, 1'b0, 8'd3, 11, 1, 4);
    repeat (10) tick();
    check("gap_state", 32'(state_dbg), 32'd5);
    check("gap_steps_done", 32'(steps_done), 32'd5);
    reset = 1'b1;
    tick();
    check_reset_values("midstep");
    reset = 1'b0;
    wait_ready("post_reset_relock");

    // Back-to-back: the second request is held off until IDLE.
    send_req(2'd0, 1'b1, 8'd2, 28, 2, 4);
    check("b2b_a_phasedir", 32'(phasedir), 32'd1);
    check("b2b_ready_low_busy", 32'(req_ready), 32'd0);
    send_req(2'd1, 1'b0, 8'd1, 16, 1, 4);
    check("b2b_b_phasesel", 32'(phasesel), 32'd1);
    check("b2b_b_phasedir", 32'(phasedir), 32'd0);
    wait_ready("b2b_done");
    check("b2b_steps_done", 32'(steps_done), 32'd3);
    check("b2b_lock_lost", 32'(lock_lost), 32'd0);

    repeat (5) tick();
    check("pulse_queue_drained", 32'(pulse_q.size()), 32'd0);
    check("busy_queue_drained", 32'(busy_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
